// File: rtl/arm7_sys_pkg.sv
// Shared arm7_sys definitions: memory map defaults, record field widths, loader state encoding.
// Imported by the loader and by the dump side so both ends agree on record layout.
package arm7_sys_pkg;

    localparam int          REC_ADDR_W    = 17;
    localparam int          REC_DATA_W    = 32;
    localparam int unsigned DEF_DMEM_BASE = 32'h0000_7000;
    localparam int unsigned DEF_MEM_LAST  = 32'h0001_0000;
    localparam logic [31:0] DEF_NOP_WORD  = 32'he1a0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN
    } ldr_state_t;

endpackage

// File: rtl/arm7_mem_loader.sv
// Image loader: background-fills arm7_sys memory, writes (addr,data) records, then releases core reset.
// Latency: fill is one word/cycle; record write appears 1 cycle after handshake, 1 record/cycle.
// Backpressure: rec_ready is high only in LOAD and drops the cycle after the last record.
module arm7_mem_loader
    import arm7_sys_pkg::*;
#(
    parameter int                ADDR_W      = REC_ADDR_W,
    parameter int                DATA_W      = REC_DATA_W,
    parameter int unsigned       DMEM_BASE   = DEF_DMEM_BASE,
    parameter int unsigned       MEM_LAST    = DEF_MEM_LAST,
    parameter logic [DATA_W-1:0] NOP_WORD    = DEF_NOP_WORD,
    parameter int                RELEASE_CYC = 4
) (
    input  logic              sysclk,
    input  logic              nRESET,
    input  logic              load_start,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_data,
    input  logic              rec_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdef,
    output logic              core_nreset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_A  = MEM_LAST[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] BASE_A  = DMEM_BASE[ADDR_W-1:0];
    localparam int                REL_W   = $clog2(RELEASE_CYC + 1);
    localparam logic [REL_W-1:0]  REL_END = REL_W'(RELEASE_CYC - 1);

    ldr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [REL_W-1:0]  rel_cnt_q;
    logic              err_q;
    logic              wr_vld_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              in_imem;
    logic              hs;

    assign hs  = rec_valid & rec_ready;
    assign err = err_q;

    always_ff @(posedge sysclk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rec_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        core_nreset = 1'b0;
        in_imem     = fill_addr_q < BASE_A;
        mem_we      = wr_vld_q;
        mem_addr    = wr_addr_q;
        mem_wdata   = wr_data_q;
        mem_wdef    = wr_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) state_d = ST_FILL;
            end
            ST_FILL: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fill_addr_q;
                mem_wdata = in_imem ? NOP_WORD : '0;
                mem_wdef  = in_imem;
                if (fill_addr_q == LAST_A) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy      = 1'b1;
                rec_ready = 1'b1;
                if (rec_valid && rec_last) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                busy = 1'b1;
                if (rel_cnt_q == REL_END) state_d = ST_RUN;
            end
            ST_RUN: begin
                done        = 1'b1;
                core_nreset = 1'b1;
                if (load_start) state_d = ST_FILL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range records are swallowed here: handshaken but never written.
    always_ff @(posedge sysclk or negedge nRESET) begin
        if (!nRESET) begin
            fill_addr_q <= '0;
            rel_cnt_q   <= '0;
            err_q       <= 1'b0;
            wr_vld_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (load_start) begin
                        fill_addr_q <= '0;
                        err_q       <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (fill_addr_q != LAST_A) fill_addr_q <= fill_addr_q + 1'b1;
                end
                ST_LOAD: begin
                    rel_cnt_q <= '0;
                    if (hs) begin
                        if (rec_addr > LAST_A) begin
                            err_q <= 1'b1;
                        end else begin
                            wr_vld_q  <= 1'b1;
                            wr_addr_q <= rec_addr;
                            wr_data_q <= rec_data;
                        end
                    end
                end
                ST_RELEASE: rel_cnt_q <= rel_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm7_mem_loader.sv
// Directed bench for arm7_mem_loader with a shrunken memory map (16 words, data region from 8).
module tb_arm7_mem_loader;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic              sysclk = 1'b0;
    logic              nRESET = 1'b0;
    logic              load_start = 1'b0;
    logic              rec_valid = 1'b0;
    logic              rec_ready;
    logic [ADDR_W-1:0] rec_addr = '0;
    logic [DATA_W-1:0] rec_data = '0;
    logic              rec_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdef;
    logic              core_nreset;
    logic              busy;
    logic              done;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    arm7_mem_loader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DMEM_BASE  (8),
        .MEM_LAST   (15),
        .NOP_WORD   (32'he1a00000),
        .RELEASE_CYC(2)
    ) dut (
        .sysclk     (sysclk),
        .nRESET     (nRESET),
        .load_start (load_start),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_addr   (rec_addr),
        .rec_data   (rec_data),
        .rec_last   (rec_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wdef   (mem_wdef),
        .core_nreset(core_nreset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Called in the first FILL cycle; returns in the first LOAD cycle.
    task automatic fill_check();
        for (int i = 0; i < 16; i++) begin
            chk("fill_we",   32'(mem_we),    32'd1);
            chk("fill_addr", 32'(mem_addr),  32'(i));
            chk("fill_wdef", 32'(mem_wdef),  (i < 8) ? 32'd1 : 32'd0);
            chk("fill_data", mem_wdata,      (i < 8) ? 32'he1a00000 : 32'd0);
            chk("fill_rdy",  32'(rec_ready), 32'd0);
            chk("fill_nrst", 32'(core_nreset), 32'd0);
            load_start = (i == 3);
            tick();
        end
        chk("load_rdy",  32'(rec_ready), 32'd1);
        chk("load_we",   32'(mem_we),    32'd0);
        chk("load_busy", 32'(busy),      32'd1);
    endtask

    task automatic send(input logic v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic l);
        rec_valid = v;
        rec_addr  = a;
        rec_data  = d;
        rec_last  = l;
        tick();
        rec_valid = 1'b0;
        rec_last  = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        chk({tag, "_we"},   32'(mem_we),   32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, mem_wdata,     d);
        chk({tag, "_wdef"}, 32'(mem_wdef), 32'd1);
    endtask

    task automatic restart();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_nrst", 32'(core_nreset), 32'd0);
        chk("rst_we",   32'(mem_we),      32'd0);
        chk("rst_rdy",  32'(rec_ready),   32'd0);
        chk("rst_busy", 32'(busy),        32'd0);
        chk("rst_done", 32'(done),        32'd0);
        chk("rst_err",  32'(err),         32'd0);
        tick();
        nRESET = 1'b1;
        tick();
        chk("idle_we", 32'(mem_we), 32'd0);

        // 1: first fill
        restart();
        fill_check();

        // 2: two back-to-back records
        send(1'b1, 17'd3, 32'hdeadbeef, 1'b0);
        chk_wr("r1", 17'd3, 32'hdeadbeef);
        chk("r1_rdy", 32'(rec_ready), 32'd1);
        send(1'b1, 17'd9, 32'h00000001, 1'b1);
        chk_wr("r2", 17'd9, 32'h00000001);
        chk("r2_rdy",  32'(rec_ready),   32'd0);
        chk("r2_nrst", 32'(core_nreset), 32'd0);
        tick();
        chk("rel_we",   32'(mem_we),      32'd0);
        chk("rel_nrst", 32'(core_nreset), 32'd0);
        chk("rel_busy", 32'(busy),        32'd1);
        tick();
        chk("run_nrst", 32'(core_nreset), 32'd1);
        chk("run_done", 32'(done),        32'd1);
        chk("run_busy", 32'(busy),        32'd0);

        // 6-style reload from RUN, then 3: out-of-range record
        restart();
        chk("rl_nrst", 32'(core_nreset), 32'd0);
        chk("rl_done", 32'(done),        32'd0);
        fill_check();
        send(1'b1, 17'd20, 32'h12345678, 1'b0);
        chk("oor_we",  32'(mem_we), 32'd0);
        chk("oor_err", 32'(err),    32'd1);
        send(1'b1, 17'd4, 32'hcafef00d, 1'b1);
        chk_wr("r4", 17'd4, 32'hcafef00d);
        tick();
        tick();
        chk("r4_done", 32'(done), 32'd1);
        chk("r4_err",  32'(err),  32'd1);

        // 6: reload clears err
        restart();
        chk("cl_err",  32'(err),  32'd0);
        chk("cl_done", 32'(done), 32'd0);
        fill_check();

        // 4: valid toggling, rec_last on non-valid cycles
        send(1'b1, 17'd1, 32'h11111111, 1'b0);
        chk_wr("t1", 17'd1, 32'h11111111);
        send(1'b0, 17'd2, 32'h22222222, 1'b1);
        chk("t2_we",  32'(mem_we),    32'd0);
        chk("t2_rdy", 32'(rec_ready), 32'd1);
        send(1'b1, 17'd5, 32'h55555555, 1'b0);
        chk_wr("t3", 17'd5, 32'h55555555);
        send(1'b0, 17'd6, 32'h66666666, 1'b1);
        chk("t4_we",  32'(mem_we),    32'd0);
        chk("t4_rdy", 32'(rec_ready), 32'd1);
        send(1'b1, 17'd6, 32'h66666666, 1'b1);
        chk_wr("t5", 17'd6, 32'h66666666);
        chk("t5_rdy", 32'(rec_ready), 32'd0);
        tick();
        tick();
        chk("t5_done", 32'(done), 32'd1);

        // 5: async reset mid-fill
        restart();
        repeat (5) tick();
        chk("mid_addr", 32'(mem_addr), 32'd5);
        #2 nRESET = 1'b0;
        #1;
        chk("ar_we",   32'(mem_we),      32'd0);
        chk("ar_nrst", 32'(core_nreset), 32'd0);
        chk("ar_busy", 32'(busy),        32'd0);
        #2 nRESET = 1'b1;
        tick();
        chk("ar_idle_we",   32'(mem_we),      32'd0);
        chk("ar_idle_nrst", 32'(core_nreset), 32'd0);
        restart();
        chk("ar_re_we",   32'(mem_we),   32'd1);
        chk("ar_re_addr", 32'(mem_addr), 32'd0);
        chk("ar_re_nrst", 32'(core_nreset), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
